// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one I-mem read per instruction, applies redirects and halt.
// Latency: fetched word is valid in the output buffer the edge after ihit; redirect target is on iaddr one cycle after the request.
// Backpressure: stall with a full buffer drops iREN combinationally and holds the PC until decode takes the instruction.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        branch,
  input  logic [31:0] btarget,
  input  logic        jr,
  input  logic [31:0] jraddr,
  input  logic        jump,
  input  logic [31:0] jtarget,
  input  logic        halt,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_npc,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {FETCH, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        vld, vld_nxt;
  logic [31:0] ins, ins_nxt;
  logic [31:0] ipc, ipc_nxt;
  logic [31:0] inpc, inpc_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        take;
  logic        can_accept;
  logic [31:0] redir_tgt;

  // Decode consumes the buffer when it is valid and not stalled; an empty or draining buffer can be refilled.
  assign take       = vld & ~stall;
  assign can_accept = ~vld | take;
  assign iREN       = (state == FETCH) & can_accept;

  assign iaddr       = pc;
  assign instr_valid = vld;
  assign instr       = ins;
  assign instr_pc    = ipc;
  assign instr_npc   = inpc;
  assign halted      = (state == HALT);
  assign fetch_cnt   = cnt;

  // Redirect target select: branch beats jr beats jump; targets are forced word-aligned.
  always_comb begin
    redir_tgt = jtarget;
    if (branch)  redir_tgt = btarget;
    else if (jr) redir_tgt = jraddr;
    redir_tgt = {redir_tgt[31:2], 2'b00};
  end

  // Next-state logic: halt > redirect > fetch hit > drain; HALT freezes everything until reset.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    vld_nxt   = vld;
    ins_nxt   = ins;
    ipc_nxt   = ipc;
    inpc_nxt  = inpc;
    cnt_nxt   = cnt;
    case (state)
      FETCH: begin
        if (halt) begin
          state_nxt = HALT;
          vld_nxt   = 1'b0;
        end else if (branch | jr | jump) begin
          // The buffered instruction is on the wrong path, so it is squashed even if taken this cycle.
          pc_nxt  = redir_tgt;
          vld_nxt = 1'b0;
        end else if (ihit & iREN) begin
          ins_nxt  = iload;
          ipc_nxt  = pc;
          inpc_nxt = pc + 32'd4;
          vld_nxt  = 1'b1;
          pc_nxt   = pc + 32'd4;
          cnt_nxt  = cnt + 32'd1;
        end else if (take) begin
          vld_nxt = 1'b0;
        end
      end
      HALT: begin
        vld_nxt = 1'b0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= FETCH;
      pc    <= RESET_PC;
      vld   <= 1'b0;
      ins   <= 32'h0;
      ipc   <= 32'h0;
      inpc  <= 32'h0;
      cnt   <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      vld   <= vld_nxt;
      ins   <= ins_nxt;
      ipc   <= ipc_nxt;
      inpc  <= inpc_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule
